// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage.
// Holds the default datapath, index and counter widths, and the load-type
// encodings used by the MEM stage to tell write-back how to extend a load.
package wb_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CNTW = 32;

  // Load-type encodings. Codes 5..7 are reserved and behave as LW.
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

endpackage

// File: rtl/load_ext.sv
// Load extension unit (purely combinational).
// Picks the addressed byte or halfword out of a little-endian 32-bit memory
// word and sign- or zero-extends it to 32 bits.
// Ports:
//   word     in  32  raw word read from data memory
//   ld_type  in  3   load type (wb_pkg encodings)
//   addr_lo  in  2   byte address bits [1:0]
//   result   out 32  extended load value
module load_ext
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the word into its four byte lanes; lane 0 is the lowest address.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr_lo];
  // Halfwords use only addr_lo[1]; a misaligned addr_lo[0] is ignored rather
  // than trapped.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (ld_type)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'd0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'd0, half_sel};
      default: result = word;  // LW and reserved codes
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Pipeline write-back stage.
// Captures MEM-stage results in the MEM/WB register, selects ALU or extended
// load data, drives the register-file write port and a same-cycle bypass to
// decode, and counts retired instructions.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   stall, flush          hold / bubble the MEM/WB register
//   in_valid .. in_mem    MEM-stage instruction fields and data
//   we, rw, rd            register-file write port
//   fwd_valid/rw/data     bypass copy of the write port
//   retired               count of valid instructions leaving WB
module wb_stage
  import wb_pkg::*;
#(
  parameter int DW   = wb_pkg::DW,
  parameter int AW   = wb_pkg::AW,
  parameter int CNTW = wb_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_we,
  input  logic            in_memtoreg,
  input  logic [2:0]      in_ld_type,
  input  logic [1:0]      in_addr_lo,
  input  logic [AW-1:0]   in_rw,
  input  logic [DW-1:0]   in_alu,
  input  logic [DW-1:0]   in_mem,
  output logic            we,
  output logic [AW-1:0]   rw,
  output logic [DW-1:0]   rd,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_rw,
  output logic [DW-1:0]   fwd_data,
  output logic [CNTW-1:0] retired
);

  logic            valid_reg;
  logic            we_reg;
  logic            memtoreg_reg;
  logic [2:0]      ld_type_reg;
  logic [1:0]      addr_lo_reg;
  logic [AW-1:0]   rw_reg;
  logic [DW-1:0]   alu_reg;
  logic [DW-1:0]   mem_reg;
  logic [CNTW-1:0] retired_reg;
  logic [DW-1:0]   load_val;

  // MEM/WB register: rst > flush > stall > load. A bubble clears every field
  // so a flushed slot looks identical to the reset state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_reg    <= 1'b0;
      we_reg       <= 1'b0;
      memtoreg_reg <= 1'b0;
      ld_type_reg  <= 3'd0;
      addr_lo_reg  <= 2'd0;
      rw_reg       <= '0;
      alu_reg      <= '0;
      mem_reg      <= '0;
    end else if (!stall) begin
      valid_reg    <= in_valid;
      we_reg       <= in_we;
      memtoreg_reg <= in_memtoreg;
      ld_type_reg  <= in_ld_type;
      addr_lo_reg  <= in_addr_lo;
      rw_reg       <= in_rw;
      alu_reg      <= in_alu;
      mem_reg      <= in_mem;
    end
  end

  // The instruction in WB retires whenever the stage advances, even if a
  // flush is replacing it with a bubble or it does not write a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
    end else if (valid_reg && !stall) begin
      retired_reg <= retired_reg + CNTW'(1);
    end
  end

  load_ext u_load_ext (
    .word    (mem_reg),
    .ld_type (ld_type_reg),
    .addr_lo (addr_lo_reg),
    .result  (load_val)
  );

  // r0 is hardwired zero, so its writes are suppressed; rd is still formed.
  assign we = valid_reg & we_reg & (rw_reg != '0);
  assign rw = rw_reg;
  assign rd = memtoreg_reg ? load_val : alu_reg;

  // Decode reads the register file in the same cycle this write commits, so
  // it needs the pending write directly.
  assign fwd_valid = we;
  assign fwd_rw    = rw;
  assign fwd_data  = rd;

  assign retired = retired_reg;

endmodule
